// File: rtl/uart_sched_pkg.sv
// Shared types and constants for the autonomous simpleuart bus sequencer.
package uart_sched_pkg;

    typedef enum logic [2:0] {
        BOOT,
        IDLE,
        WR,
        POLL,
        POLL_W,
        RD,
        RD_W
    } state_e;

    // simpleuart register map and status bit layout
    localparam logic ADDR_DATA = 1'b0;
    localparam logic ADDR_STAT = 1'b1;
    localparam int   STAT_RDY  = 0;

    // Clocks from a data write until the transmitter can take another byte
    function automatic logic [15:0] char_clks(input int div);
        return 16'(10 * (div + 2) + 2);
    endfunction

    // Hold-off after reset that covers the UART's 15-bit dummy frame
    function automatic logic [15:0] boot_clks(input int div);
        return 16'(16 * (div + 2));
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter; the last-grant register advances only when
// a grant is actually accepted, so an unused decision does not rotate priority.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic [1:0] accept,
    output logic [1:0] grant
);

    logic last_q;
    logic last_d;

    // Grant the lone requester, or on contention the one that did not win last
    always_comb begin
        grant  = 2'b00;
        last_d = last_q;
        if (req == 2'b11) begin
            grant = last_q ? 2'b01 : 2'b10;
        end else begin
            grant = req;
        end
        if (accept[0]) begin
            last_d = 1'b0;
        end else if (accept[1]) begin
            last_d = 1'b1;
        end
    end

    // Last-grant register starts at 1 so requester 0 wins the first contention
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/uart_bus_sched.sv
// Drives the simpleuart register bus without a CPU: paces TX writes from two
// round-robin requesters and drains RX bytes into a one-entry holding register.
module uart_bus_sched
    import uart_sched_pkg::*;
#(
    parameter int DIV = 27
) (
    input  logic       CLK,
    input  logic       RESET,
    output logic       u_cs,
    output logic       u_rw,
    output logic       u_addr,
    output logic [7:0] u_di,
    input  logic [7:0] u_do,
    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    output logic       req1_ready,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    input  logic       rx_ready,
    output logic       tx_busy
);

    localparam logic [15:0] CHAR_CLKS = char_clks(DIV);
    localparam logic [15:0] BOOT_CLKS = boot_clks(DIV);

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        cs_q, cs_d;
    logic        rw_q, rw_d;
    logic        addr_q, addr_d;
    logic [7:0]  di_q, di_d;
    logic [1:0]  rdy_q, rdy_d;
    logic        rxv_q, rxv_d;
    logic [7:0]  rxd_q, rxd_d;
    logic [1:0]  grant;

    rr_arb2 u_arb (
        .clk    (CLK),
        .rst    (RESET),
        .req    ({req1_valid, req0_valid}),
        .accept (rdy_q),
        .grant  (grant)
    );

    // Next-state logic; bus outputs are set on entry to WR/POLL/RD so the strobe
    // coincides with that state and read data is present in the following state
    always_comb begin
        state_d = state_q;
        cnt_d   = (cnt_q != 16'd0) ? cnt_q - 16'd1 : cnt_q;
        cs_d    = 1'b0;
        rw_d    = rw_q;
        addr_d  = addr_q;
        di_d    = di_q;
        rdy_d   = 2'b00;
        rxv_d   = rxv_q && !rx_ready;
        rxd_d   = rxd_q;
        case (state_q)
            BOOT: begin
                if (cnt_q == 16'd0) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if ((cnt_q == 16'd0) && (req0_valid || req1_valid)) begin
                    state_d = WR;
                    cs_d    = 1'b1;
                    rw_d    = 1'b0;
                    addr_d  = ADDR_DATA;
                    di_d    = grant[1] ? req1_data : req0_data;
                    rdy_d   = grant;
                end else if (!rxv_q) begin
                    state_d = POLL;
                    cs_d    = 1'b1;
                    rw_d    = 1'b1;
                    addr_d  = ADDR_STAT;
                end
            end
            WR: begin
                cnt_d   = CHAR_CLKS;
                state_d = IDLE;
            end
            POLL: begin
                state_d = POLL_W;
            end
            POLL_W: begin
                if (u_do[STAT_RDY]) begin
                    state_d = RD;
                    cs_d    = 1'b1;
                    rw_d    = 1'b1;
                    addr_d  = ADDR_DATA;
                end else begin
                    state_d = IDLE;
                end
            end
            RD: begin
                state_d = RD_W;
            end
            RD_W: begin
                rxv_d   = 1'b1;
                rxd_d   = u_do;
                state_d = IDLE;
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    // All state and outputs registered; reset abandons any bus transfer in flight
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= BOOT;
            cnt_q   <= BOOT_CLKS;
            cs_q    <= 1'b0;
            rw_q    <= 1'b1;
            addr_q  <= ADDR_DATA;
            di_q    <= 8'h00;
            rdy_q   <= 2'b00;
            rxv_q   <= 1'b0;
            rxd_q   <= 8'h00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cs_q    <= cs_d;
            rw_q    <= rw_d;
            addr_q  <= addr_d;
            di_q    <= di_d;
            rdy_q   <= rdy_d;
            rxv_q   <= rxv_d;
            rxd_q   <= rxd_d;
        end
    end

    assign u_cs       = cs_q;
    assign u_rw       = rw_q;
    assign u_addr     = addr_q;
    assign u_di       = di_q;
    assign req0_ready = rdy_q[0];
    assign req1_ready = rdy_q[1];
    assign rx_valid   = rxv_q;
    assign rx_data    = rxd_q;
    assign tx_busy    = (cnt_q != 16'd0);

endmodule
